// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared FSM states and sweep constants for the or_and gate sweeper.
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int IDX_W = 3;
  localparam int NUM_COMB = 8;
  localparam logic [7:0] EXPECTED_OR_AND = 8'hE0;
endpackage

// File: rtl/gate_sweep_ctrl_sweep_hold_timer.sv
// sweep_hold_timer: counts 0..HOLD_CYCLES-1 while enabled, ticks on the last count.
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = enable && cnt == 8'(HOLD_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clear || tick) ? 8'd0 : enable ? cnt + 8'd1 : cnt;
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives all 8 {C,A,B} combinations into an or_and gate and captures E per index.
// Optional golden compare enabled by defining GATE_SWEEP_CHECK_EN.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                E,
  output logic                A,
  output logic                B,
  output logic                C,
  output logic                busy,
  output logic                done,
  output logic [NUM_COMB-1:0] table_out,
  output logic                mismatch
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic clr, tick, last;
  assign last = idx == IDX_W'(NUM_COMB - 1);
  assign busy = state == DRIVE;
  assign done = state == DONE;
  always_comb begin
    clr = start && state != DRIVE;
    state_n = clr ? DRIVE : (busy && tick && last) ? DONE : state;
    idx_n = clr ? '0 : tick ? idx + 1'b1 : idx;
  end
  sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clear(clr), .enable(busy), .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      {C, A, B} <= 3'b000;
      table_out <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      {C, A, B} <= (state_n == DRIVE) ? idx_n : 3'b000;
      if (clr) table_out <= '0;
      else if (tick) table_out[idx] <= E;
    end
  end
`ifdef GATE_SWEEP_CHECK_EN
  logic mm;
  // compare includes the bit being captured on the same edge
  always_ff @(posedge clk) begin
    if (rst || clr) mm <= 1'b0;
    else if (tick && last) mm <= {E, table_out[NUM_COMB-2:0]} != EXPECTED_OR_AND;
  end
  assign mismatch = mm;
`else
  assign mismatch = 1'b0;
`endif
endmodule
